// File: rtl/mda_pkg.sv
// Shared constants and types for the MDA character/attribute RAM path.
package mda_pkg;
   localparam int MDA_COLS   = 80;
   localparam int MDA_ROWS   = 25;
   localparam int MDA_CELL_W = 9;
   localparam int MDA_ADDR_W = 11;

   typedef struct packed {
      logic [7:0] attr;
      logic [7:0] code;
   } mda_cell_t;

   typedef enum logic {
      ST_IDLE,
      ST_FILL
   } mda_state_t;

   // Ownership of the word returning from the RAM two edges after issue.
   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_DISP,
      TAG_HRD,
      TAG_HZERO
   } mda_tag_t;
endpackage

// File: rtl/mda_addr_calc.sv
// Linear cell address row*COLS + col with an in-range flag; purely combinational.
module mda_addr_calc
   import mda_pkg::*;
#(
   parameter int COLS   = MDA_COLS,
   parameter int ROWS   = MDA_ROWS,
   parameter int ADDR_W = MDA_ADDR_W
) (
   input  logic [6:0]        col,
   input  logic [4:0]        row,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   logic [15:0] lin;

   generate
      if (COLS == 80) begin : g_shift
         assign lin = {5'd0, row, 6'd0} + {7'd0, row, 4'd0} + {9'd0, col};
      end else begin : g_mul
         assign lin = 16'(row) * 16'(COLS) + 16'(col);
      end
   endgenerate

   assign addr     = lin[ADDR_W-1:0];
   assign in_range = (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
endmodule

// File: rtl/mda_vram_arb.sv
// Single-port VRAM arbiter: reserved display slot, then clear-screen fill, then host.
module mda_vram_arb
   import mda_pkg::*;
#(
   parameter int COLS      = MDA_COLS,
   parameter int ROWS      = MDA_ROWS,
   parameter int DISP_SLOT = 0,
   parameter int ADDR_W    = MDA_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        char_pixel,
   input  logic [6:0]        col,
   input  logic [4:0]        row,
   output logic [7:0]        disp_code,
   output logic [7:0]        disp_attr,
   input  logic              h_valid,
   output logic              h_ready,
   input  logic              h_we,
   input  logic [6:0]        h_col,
   input  logic [4:0]        h_row,
   input  logic [15:0]       h_wdata,
   output logic              h_rvalid,
   output logic [15:0]       h_rdata,
   input  logic              fill_start,
   input  logic [15:0]       fill_data,
   output logic              fill_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

   mda_state_t        state, state_nx;
   logic [ADDR_W-1:0] disp_addr, host_addr, fill_cnt;
   logic              disp_ok, host_ok, disp_slot, host_acc, fill_go;
   mda_cell_t         fill_word, rcell;
   mda_tag_t          tag_pipe [1:0];

   mda_addr_calc #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_disp_addr (
      .col(col), .row(row), .addr(disp_addr), .in_range(disp_ok)
   );
   mda_addr_calc #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_host_addr (
      .col(h_col), .row(h_row), .addr(host_addr), .in_range(host_ok)
   );

   assign disp_slot = (char_pixel == 4'(DISP_SLOT)) && disp_ok;
   assign fill_busy = (state == ST_FILL);
   assign fill_go   = (state == ST_FILL) && !disp_slot;
   assign host_acc  = h_valid && h_ready;
   assign rcell     = mem_rdata;

   always_comb begin
      state_nx = state;
      h_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            // A fill request pre-empts a host handshake in the same cycle.
            h_ready = !disp_slot && !fill_start;
            if (fill_start) state_nx = ST_FILL;
         end
         ST_FILL: if (fill_go && fill_cnt == LAST_ADDR) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (rst) h_ready = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         fill_cnt    <= '0;
         fill_word   <= '0;
         tag_pipe[0] <= TAG_NONE;
         tag_pipe[1] <= TAG_NONE;
      end else begin
         mem_we      <= 1'b0;
         tag_pipe[0] <= TAG_NONE;
         tag_pipe[1] <= tag_pipe[0];
         if (disp_slot) begin
            mem_addr    <= disp_addr;
            tag_pipe[0] <= TAG_DISP;
         end else if (fill_go) begin
            mem_addr  <= fill_cnt;
            mem_we    <= 1'b1;
            mem_wdata <= fill_word;
            fill_cnt  <= fill_cnt + 1'b1;
         end else if (host_acc) begin
            if (!host_ok) begin
               // Off-screen: writes vanish, reads still answer (with zero) on time.
               tag_pipe[0] <= h_we ? TAG_NONE : TAG_HZERO;
            end else begin
               mem_addr <= host_addr;
               mem_we   <= h_we;
               if (h_we) mem_wdata   <= h_wdata;
               else      tag_pipe[0] <= TAG_HRD;
            end
         end
         if (state == ST_IDLE && fill_start) begin
            fill_cnt  <= '0;
            fill_word <= fill_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_code <= '0;
         disp_attr <= '0;
         h_rvalid  <= 1'b0;
         h_rdata   <= '0;
      end else begin
         h_rvalid <= 1'b0;
         case (tag_pipe[1])
            TAG_DISP: begin
               disp_code <= rcell.code;
               disp_attr <= rcell.attr;
            end
            TAG_HRD: begin
               h_rvalid <= 1'b1;
               h_rdata  <= mem_rdata;
            end
            TAG_HZERO: begin
               h_rvalid <= 1'b1;
               h_rdata  <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mda_vram_arb.sv
// Randomized bench for mda_vram_arb against a cycle-level behavioural model of the VRAM arbiter.
module tb_mda_vram_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  char_pixel;
   logic [6:0]  col;
   logic [4:0]  row;
   logic [7:0]  disp_code, disp_attr;
   logic        h_valid, h_ready, h_we;
   logic [6:0]  h_col;
   logic [4:0]  h_row;
   logic [15:0] h_wdata;
   logic        h_rvalid;
   logic [15:0] h_rdata;
   logic        fill_start;
   logic [15:0] fill_data;
   logic        fill_busy;
   logic [10:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   always #5 clk = ~clk;

   mda_vram_arb dut (
      .clk(clk), .rst(rst), .char_pixel(char_pixel), .col(col), .row(row),
      .disp_code(disp_code), .disp_attr(disp_attr),
      .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_col(h_col), .h_row(h_row),
      .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .fill_start(fill_start), .fill_data(fill_data), .fill_busy(fill_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous single-port RAM; poke is a backdoor preload used only during reset.
   logic [15:0] ram [0:2047] = '{default: 16'h0};
   logic        poke = 1'b0;
   logic [10:0] poke_a = '0;
   logic [15:0] poke_d = '0;
   always @(posedge clk) begin
      if (poke)        ram[poke_a]   <= poke_d;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Reference model state: screen contents plus pending returns keyed by due edge.
   typedef struct {
      int          due;
      bit          host;
      logic [15:0] data;
   } ev_t;

   logic [15:0] shadow [0:2047];
   ev_t         evq [$];
   bit          m_fill;
   int          m_cnt;
   logic [15:0] m_fword;
   logic [10:0] exp_addr;
   bit          exp_we, exp_rvalid;
   logic [15:0] exp_wdata, exp_rdata, exp_disp;
   int          cyc, errs, checks;
   bit          acc;
   logic        rdy_s;
   int          p_cp, p_col, p_row;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: model decides what the upcoming edge should do, then outputs are compared after it.
   task automatic tick();
      bit r, ds, inr, was_fill;
      int a, ha;
      ev_t ev;
      #1;
      r     = rst;
      rdy_s = h_ready;
      acc   = 1'b0;
      if (r) begin
         chk("h_ready_rst", h_ready, 0);
      end else begin
         a        = int'(row) * 80 + int'(col);
         ds       = (char_pixel == 4'd0) && (col < 7'd80) && (row < 5'd25);
         was_fill = m_fill;
         chk("h_ready", h_ready, !m_fill && !ds && !fill_start);
         acc    = h_valid && !m_fill && !ds && !fill_start;
         exp_we = 1'b0;
         if (ds) begin
            evq.push_back('{due: cyc + 3, host: 1'b0, data: shadow[a]});
            exp_addr = a[10:0];
         end else if (m_fill) begin
            shadow[m_cnt] = m_fword;
            exp_addr      = m_cnt[10:0];
            exp_we        = 1'b1;
            exp_wdata     = m_fword;
            m_cnt++;
            if (m_cnt == 2000) m_fill = 1'b0;
         end else if (acc) begin
            ha  = int'(h_row) * 80 + int'(h_col);
            inr = (h_col < 7'd80) && (h_row < 5'd25);
            if (h_we) begin
               if (inr) begin
                  shadow[ha] = h_wdata;
                  exp_addr   = ha[10:0];
                  exp_we     = 1'b1;
                  exp_wdata  = h_wdata;
               end
            end else begin
               evq.push_back('{due: cyc + 3, host: 1'b1, data: inr ? shadow[ha] : 16'h0});
               if (inr) exp_addr = ha[10:0];
            end
         end
         if (!was_fill && fill_start) begin
            m_fill  = 1'b1;
            m_cnt   = 0;
            m_fword = fill_data;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_rvalid = 1'b0;
      if (r) begin
         m_fill = 1'b0; m_cnt = 0; evq.delete();
         exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
         exp_disp = '0; exp_rdata = '0;
      end
      while (evq.size() > 0 && evq[0].due == cyc) begin
         ev = evq.pop_front();
         if (ev.host) begin
            exp_rvalid = 1'b1;
            exp_rdata  = ev.data;
         end else begin
            exp_disp = ev.data;
         end
      end
      chk("fill_busy", fill_busy, m_fill);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      if (exp_we || r) chk("mem_wdata", mem_wdata, exp_wdata);
      chk("h_rvalid", h_rvalid, exp_rvalid);
      if (exp_rvalid || r) chk("h_rdata", h_rdata, exp_rdata);
      chk("disp", {disp_attr, disp_code}, exp_disp);
   endtask

   // Position generator with some off-screen columns and rows to exercise free slots.
   task automatic adv_pos();
      p_cp++;
      if (p_cp == 9) begin
         p_cp = 0;
         p_col++;
         if (p_col == 88) begin
            p_col = 0;
            p_row++;
            if (p_row == 27) p_row = 0;
         end
      end
      char_pixel = 4'(p_cp);
      col        = 7'(p_col);
      row        = 5'(p_row);
   endtask

   task automatic new_req();
      h_valid = ($urandom % 4) != 0;
      h_we    = 1'($urandom % 2);
      h_col   = 7'($urandom_range(0, 84));
      h_row   = 5'($urandom_range(0, 27));
      h_wdata = 16'($urandom);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 2048; i++) shadow[i] = 16'h0;
      errs = 0; checks = 0; cyc = 0;
      m_fill = 1'b0; m_cnt = 0; m_fword = '0;
      exp_addr = '0; exp_we = 1'b0; exp_wdata = '0; exp_disp = '0; exp_rdata = '0; exp_rvalid = 1'b0;
      p_cp = 0; p_col = 0; p_row = 0;
      rst = 1'b1; char_pixel = '0; col = '0; row = '0;
      h_valid = 1'b0; h_we = 1'b0; h_col = '0; h_row = '0; h_wdata = '0;
      fill_start = 1'b0; fill_data = '0;

      poke = 1'b1; poke_a = 11'd81; poke_d = 16'h0741; shadow[81] = 16'h0741;
      tick();
      poke = 1'b0;
      tick();
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", fill_busy, 0);

      // Display fetch of cell (1,1).
      rst = 1'b0; char_pixel = 4'd0; col = 7'd1; row = 5'd1;
      tick();
      chk("disp_slot_addr", mem_addr, 81);
      chk("disp_slot_rdy", rdy_s, 0);
      char_pixel = 4'd1; tick();
      char_pixel = 4'd2; tick();
      chk("disp_code", disp_code, 8'h41);
      chk("disp_attr", disp_attr, 8'h07);

      // Host write then read at the last cell.
      char_pixel = 4'd3; h_valid = 1'b1; h_we = 1'b1; h_col = 7'd79; h_row = 5'd24; h_wdata = 16'hA55A;
      tick();
      chk("hw_acc", rdy_s, 1);
      chk("hw_addr", mem_addr, 1999);
      chk("hw_we", mem_we, 1);
      h_we = 1'b0; char_pixel = 4'd4;
      tick();
      chk("hr_acc", rdy_s, 1);
      h_valid = 1'b0;
      char_pixel = 4'd5; tick();
      char_pixel = 4'd6; tick();
      chk("hr_rvalid", h_rvalid, 1);
      chk("hr_rdata", h_rdata, 16'hA55A);
      char_pixel = 4'd7; tick();
      chk("hr_pulse", h_rvalid, 0);

      // Off-screen host read answers zero.
      char_pixel = 4'd8; h_valid = 1'b1; h_col = 7'd80; h_row = 5'd3;
      tick();
      chk("oob_acc", rdy_s, 1);
      h_valid = 1'b0; char_pixel = 4'd3;
      tick(); tick();
      chk("oob_rvalid", h_rvalid, 1);
      chk("oob_rdata", h_rdata, 0);

      // Slot on an off-screen row is free for the host.
      char_pixel = 4'd0; col = 7'd5; row = 5'd25; h_valid = 1'b1; h_col = 7'd10; h_row = 5'd2;
      tick();
      chk("row25_free", rdy_s, 1);
      h_valid = 1'b0; char_pixel = 4'd1;
      tick(); tick();

      // Fill and host handshake together: fill wins.
      char_pixel = 4'd2; col = 7'd0; row = 5'd0;
      h_valid = 1'b1; h_we = 1'b1; h_col = 7'd0; h_row = 5'd0; h_wdata = 16'hDEAD;
      fill_start = 1'b1; fill_data = 16'h0720;
      tick();
      fill_start = 1'b0;
      chk("fill_win_rdy", rdy_s, 0);
      chk("fill_busy_on", fill_busy, 1);
      p_cp = 2; p_col = 0; p_row = 0;
      n = 1;
      while (fill_busy && n < 3000) begin
         adv_pos();
         if ($urandom % 8 == 0) new_req();
         tick();
         n++;
      end
      chk("fill_len_ok", (n >= 2000 && n <= 2300), 1);

      h_valid = 1'b1; h_we = 1'b0; h_col = 7'd34; h_row = 5'd15;
      n = 0;
      do begin adv_pos(); tick(); n++; end while (!acc && n < 20);
      chk("fill_rd_acc", rdy_s, 1);
      h_valid = 1'b0;
      adv_pos(); tick();
      adv_pos(); tick();
      chk("fill_rd_rvalid", h_rvalid, 1);
      chk("fill_rd_data", h_rdata, 16'h0720);

      // Randomized contention with continuously offered host traffic.
      new_req();
      for (int i = 0; i < 3000; i++) begin
         adv_pos();
         if (acc || !h_valid) new_req();
         tick();
      end

      // Reset aborts an in-flight read.
      char_pixel = 4'd5; h_valid = 1'b1; h_we = 1'b0; h_col = 7'd1; h_row = 5'd1;
      tick();
      chk("abort_rd_acc", rdy_s, 1);
      h_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick(); tick();

      // Reset mid-fill, then restart from address 0.
      p_cp = 5; p_col = 0; p_row = 0;
      char_pixel = 4'd5; col = 7'd0; row = 5'd0;
      fill_start = 1'b1; fill_data = 16'($urandom);
      tick();
      fill_start = 1'b0;
      n = 0;
      while (m_cnt < 500 && n < 1000) begin adv_pos(); tick(); n++; end
      rst = 1'b1;
      tick();
      chk("rf_busy", fill_busy, 0);
      chk("rf_we", mem_we, 0);
      chk("rf_addr", mem_addr, 0);
      chk("rf_rvalid", h_rvalid, 0);
      chk("rf_disp", {disp_attr, disp_code}, 0);
      chk("rf_rdy", h_ready, 0);
      rst = 1'b0; char_pixel = 4'd3; fill_start = 1'b1; fill_data = 16'h5A5A;
      tick();
      fill_start = 1'b0; char_pixel = 4'd4;
      tick();
      chk("refill_we", mem_we, 1);
      chk("refill_addr0", mem_addr, 0);
      chk("refill_data", mem_wdata, 16'h5A5A);
      p_cp = 4;
      n = 0;
      while (fill_busy && n < 3000) begin adv_pos(); tick(); n++; end
      chk("refill_done", fill_busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
